data_island_scheduler: RTL



---
 rtl/data_island_scheduler.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_island_scheduler.sv
// Data island scheduler: times the data island inside each blanking interval,
// drives the per-character phase strobes for the TMDS encoders and
// round-robin arbitrates the packet serializer between the packet sources.
module data_island_scheduler #(
    parameter int NUM_SOURCES = 4,
    parameter int SEL_WIDTH   = 3,
    parameter int MAX_PACKETS = 18,
    parameter int LEAD_GAP    = 10,
    parameter int TAIL_GAP    = 12
) (
    input  logic                   pixelClock,
    input  logic                   resetN,
    input  logic                   videoEnable,
    input  logic                   hSync,
    input  logic                   syncIsActiveLow,
    input  logic [11:0]            hBlankLength,
    input  logic [NUM_SOURCES-1:0] req,
    output logic [NUM_SOURCES-1:0] grant,
    output logic [SEL_WIDTH-1:0]   packetSelect,
    output logic                   islandActive,
    output logic                   preambleActive,
    output logic                   guardBandActive,
    output logic                   packetActive,
    output logic                   firstPacketClock,
    output logic                   overrun
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] PREAMBLE    = 3'd1;
    localparam logic [2:0] LEAD_GUARD  = 3'd2;
    localparam logic [2:0] PACKET      = 3'd3;
    localparam logic [2:0] TRAIL_GUARD = 3'd4;

    localparam int PKT_CNT_W = $clog2(MAX_PACKETS + 1);

    // Blank characters needed for preamble, both guard pairs, one packet and the gaps.
    localparam logic [15:0] ONE_PACKET_SPAN  = 16'(LEAD_GAP + 12 + 32 + TAIL_GAP);
    // Remaining characters needed, seen from the last character of a packet,
    // to append one more packet plus the trailing guard and tail gap.
    localparam logic [15:0] NEXT_PACKET_SPAN = 16'(35 + TAIL_GAP);
    // The island is armed one character early so the first preamble
    // character coincides with elapsed == LEAD_GAP.
    localparam logic [11:0] ARM_POINT        = 12'(LEAD_GAP - 1);
    localparam logic [SEL_WIDTH-1:0] LAST_SOURCE = SEL_WIDTH'(NUM_SOURCES - 1);
    localparam logic [PKT_CNT_W-1:0] PACKET_LIMIT = PKT_CNT_W'(MAX_PACKETS);

    logic [2:0]             state;
    logic [4:0]             phase;
    logic [PKT_CNT_W-1:0]   packetCount;
    logic [SEL_WIDTH-1:0]   selectReg;
    logic [SEL_WIDTH-1:0]   rrPointer;
    logic                   done;
    logic                   overrunReg;

    logic [11:0]            elapsed;
    logic [11:0]            elapsedNow;
    logic                   videoEnableQ;
    logic                   hSyncActiveQ;
    logic                   hSyncActive;
    logic                   zeroElapsed;

    logic [SEL_WIDTH-1:0]   winner;
    logic                   winnerValid;
    logic [SEL_WIDTH-1:0]   winnerNextPtr;

    logic                   oneFits;
    logic                   moreRoom;
    logic                   startIsland;
    logic                   atLeadGrant;
    logic                   continuePacket;
    logic                   abort;
    logic                   issueGrant;

    // Line timing: detect blank start / vertical-blank line start and form the current elapsed count.
    always_comb begin
        hSyncActive = hSync ^ syncIsActiveLow;
        zeroElapsed = (!videoEnable && videoEnableQ) ||
                      (!videoEnable && hSyncActive && !hSyncActiveQ);
        elapsedNow  = zeroElapsed ? 12'd0 : elapsed;
    end

    // Elapsed-character counter, saturating, advanced only during blanking.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            elapsed      <= 12'd0;
            videoEnableQ <= 1'b0;
            hSyncActiveQ <= 1'b0;
        end else begin
            videoEnableQ <= videoEnable;
            hSyncActiveQ <= hSyncActive;
            if (!videoEnable)
                elapsed <= (elapsedNow == 12'hFFF) ? 12'hFFF : elapsedNow + 12'd1;
        end
    end

    // Round-robin arbiter: lowest requesting index at or after rrPointer, else wrap to the lowest.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        winner      = '0;
        winnerValid = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (!winnerValid && req[i] && (SEL_WIDTH'(i) >= rrPointer)) begin
                winnerValid = 1'b1;
                winner      = SEL_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (!winnerValid && req[i]) begin
                winnerValid = 1'b1;
                winner      = SEL_WIDTH'(i);
            end
        end
        winnerNextPtr = (winner == LAST_SOURCE) ? '0 : winner + SEL_WIDTH'(1);
    end

    // Scheduling decisions for the current character.
    always_comb begin
        oneFits        = ONE_PACKET_SPAN <= {4'b0, hBlankLength};
        moreRoom       = ({4'b0, elapsedNow} + NEXT_PACKET_SPAN) <= {4'b0, hBlankLength};
        abort          = videoEnable && (state != IDLE);
        startIsland    = (state == IDLE) && !videoEnable && !done &&
                         (elapsedNow == ARM_POINT) && (|req) && oneFits;
        atLeadGrant    = (state == LEAD_GUARD) && (phase == 5'd1);
        continuePacket = (state == PACKET) && (phase == 5'd31) && winnerValid &&
                         (packetCount < PACKET_LIMIT) && moreRoom;
        issueGrant     = !abort && winnerValid && (atLeadGrant || continuePacket);
    end

    // Island sequencer: preamble, leading guard, packets, trailing guard.
    // NOTE: reset is asynchronous so a mid-island reset drops every strobe without waiting for a clock.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            phase       <= 5'd0;
            packetCount <= '0;
            selectReg   <= '0;
            rrPointer   <= '0;
            overrunReg  <= 1'b0;
        end else begin
            if (issueGrant) begin
                selectReg <= winner;
                rrPointer <= winnerNextPtr;
            end
            if (abort) begin
                state      <= IDLE;
                phase      <= 5'd0;
                overrunReg <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (startIsland) begin
                            state       <= PREAMBLE;
                            phase       <= 5'd0;
                            packetCount <= '0;
                        end
                    end
                    PREAMBLE: begin
                        if (phase == 5'd7) begin
                            state <= LEAD_GUARD;
                            phase <= 5'd0;
                        end else begin
                            phase <= phase + 5'd1;
                        end
                    end
                    LEAD_GUARD: begin
                        if (phase == 5'd1) begin
                            // All requests withdrawn during the preamble: close an empty island.
                            state       <= issueGrant ? PACKET : TRAIL_GUARD;
                            phase       <= 5'd0;
                            packetCount <= issueGrant ? PKT_CNT_W'(1) : '0;
                        end else begin
                            phase <= phase + 5'd1;
                        end
                    end
                    PACKET: begin
                        if (phase == 5'd31) begin
                            phase <= 5'd0;
                            if (issueGrant)
                                packetCount <= packetCount + PKT_CNT_W'(1);
                            else
                                state <= TRAIL_GUARD;
                        end else begin
                            phase <= phase + 5'd1;
                        end
                    end
                    TRAIL_GUARD: begin
                        if (phase == 5'd1) begin
                            state <= IDLE;
                            phase <= 5'd0;
                        end else begin
                            phase <= phase + 5'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        phase <= 5'd0;
                    end
                endcase
            end
        end
    end

    // One island per line: done blocks a restart until elapsed is zeroed again.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN)
            done <= 1'b0;
        else if (zeroElapsed)
            done <= 1'b0;
        else if (abort || ((state == TRAIL_GUARD) && (phase == 5'd1)))
            done <= 1'b1;
    end

    // Output decode from the sequencer state.
    always_comb begin
        grant            = issueGrant ? (NUM_SOURCES'(1) << winner) : '0;
        packetSelect     = issueGrant ? winner : selectReg;
        islandActive     = (state != IDLE);
        preambleActive   = (state == PREAMBLE);
        guardBandActive  = (state == LEAD_GUARD) || (state == TRAIL_GUARD);
        packetActive     = (state == PACKET);
        firstPacketClock = (state == PACKET) && (phase == 5'd0);
        overrun          = overrunReg;
    end

endmodule
